uart_tx_scheduler: RTL and testbench

- Shares the single UART transmit byte channel between three sources: manual command source, script engine, and an internal heartbeat/query timer.
- Stamps each outgoing byte with its packet type in bits [1:0].
- Sequences the UART TX handshake (start, busy rise, busy fall, inter-byte gap) and flags transmitter stalls.
- Sits between the command sources and the UART TX core, alongside the receive-side feedback decoder.

---
 rtl/uart_cmd_pkg.sv | 25 ++
 rtl/tx_hb_timer.sv | 42 ++++
 rtl/uart_tx_scheduler.sv | 134 +++++++++++++
 tb/tb_uart_tx_scheduler.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared packet-type codes, query byte and TX scheduler state encoding
// for the UART command path (transmit scheduler and receive decoder).
package uart_cmd_pkg;

   localparam logic [1:0] PKT_SCRIPT   = 2'b00;
   localparam logic [1:0] PKT_MANUAL   = 2'b01;
   localparam logic [1:0] PKT_QUERY    = 2'b10;
   localparam logic [1:0] PKT_FEEDBACK = 2'b11;

   localparam logic [7:0] QUERY_BYTE = {6'b000000, PKT_QUERY};

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_BUSY = 2'd1,
      WAIT_DONE = 2'd2,
      GAP       = 2'd3
   } tx_state_t;

   // Payload bits [7:2] are kept and the packet type replaces bits [1:0].
   function automatic logic [7:0] stamp_byte(input logic [7:0] payload,
                                             input logic [1:0] pkt_type);
      return {payload[7:2], pkt_type};
   endfunction

endpackage

// File: rtl/tx_hb_timer.sv
// Free-running heartbeat timer: raises hb_pending once per HB_PERIOD
// cycles and holds it until the scheduler dispatches the query.
module tx_hb_timer #(
   parameter int HB_PERIOD = 1000000
) (
   input  logic uart_clk,
   input  logic rst_n,
   input  logic hb_clear,
   output logic hb_pending
);

   localparam int CW = (HB_PERIOD > 1) ? $clog2(HB_PERIOD) : 1;
   localparam logic [CW-1:0] HB_LAST = CW'(HB_PERIOD - 1);

   logic [CW-1:0] hb_count;
   logic          hb_wrap;

   assign hb_wrap = (hb_count == HB_LAST);

   // Period counter runs 0..HB_PERIOD-1 and wraps.
   always_ff @(posedge uart_clk or negedge rst_n) begin
      if (!rst_n) begin
         hb_count <= '0;
      end else if (hb_wrap) begin
         hb_count <= '0;
      end else begin
         hb_count <= hb_count + CW'(1);
      end
   end

   // A wrap marks a query as owed; a new wrap outranks a same-cycle clear, and wraps never stack.
   always_ff @(posedge uart_clk or negedge rst_n) begin
      if (!rst_n) begin
         hb_pending <= 1'b0;
      end else if (hb_wrap) begin
         hb_pending <= 1'b1;
      end else if (hb_clear) begin
         hb_pending <= 1'b0;
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Arbitrates the UART TX byte channel between heartbeat queries, the
// script engine and the manual source, stamps packet types, sequences
// the start/busy/gap handshake and flags transmitter start stalls.
module uart_tx_scheduler
   import uart_cmd_pkg::*;
#(
   parameter int HB_PERIOD  = 1000000,
   parameter int GAP_CYCLES = 16,
   parameter int START_TO   = 8
) (
   input  logic       uart_clk,
   input  logic       rst_n,
   input  logic       script_mode,
   input  logic       man_req,
   input  logic [7:0] man_data,
   output logic       man_ack,
   input  logic       scr_req,
   input  logic [7:0] scr_data,
   output logic       scr_ack,
   input  logic       tx_busy,
   output logic       tx_start,
   output logic [7:0] tx_data,
   output logic       sched_busy,
   output logic       err_timeout
);

   localparam int CNT_MAX = (START_TO > GAP_CYCLES) ? START_TO : GAP_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] START_LAST = CW'(START_TO - 1);
   localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

   tx_state_t     state;
   logic [CW-1:0] phase_cnt;
   logic          hb_pending;
   logic          hb_clear;

   logic man_valid;
   logic scr_valid;
   logic arb_open;
   logic dispatch_query;
   logic dispatch_man;
   logic dispatch_scr;
   logic drop_man;
   logic drop_scr;

   tx_hb_timer #(
      .HB_PERIOD (HB_PERIOD)
   ) u_hb_timer (
      .uart_clk   (uart_clk),
      .rst_n      (rst_n),
      .hb_clear   (hb_clear),
      .hb_pending (hb_pending)
   );

   // A request that was acked last cycle is still held high by its source
   // for one more cycle, so it is masked to avoid a second ack.
   assign man_valid = man_req && !man_ack;
   assign scr_valid = scr_req && !scr_ack;

   assign arb_open       = (state == IDLE) && !tx_busy;
   assign dispatch_query = arb_open && hb_pending;
   assign dispatch_man   = arb_open && !hb_pending && !script_mode && man_valid;
   assign dispatch_scr   = arb_open && !hb_pending &&  script_mode && scr_valid;
   assign drop_man       = arb_open &&  script_mode && man_valid;
   assign drop_scr       = arb_open && !script_mode && scr_valid;
   assign hb_clear       = dispatch_query;

   // Scheduler FSM with registered strobes, acks, data and status flags.
   always_ff @(posedge uart_clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         phase_cnt   <= '0;
         tx_start    <= 1'b0;
         tx_data     <= 8'h00;
         man_ack     <= 1'b0;
         scr_ack     <= 1'b0;
         sched_busy  <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         man_ack  <= dispatch_man || drop_man;
         scr_ack  <= dispatch_scr || drop_scr;
         case (state)
            IDLE: begin
               if (dispatch_query || dispatch_man || dispatch_scr) begin
                  tx_start   <= 1'b1;
                  phase_cnt  <= '0;
                  sched_busy <= 1'b1;
                  state      <= WAIT_BUSY;
                  if (dispatch_query) begin
                     tx_data <= QUERY_BYTE;
                  end else if (dispatch_man) begin
                     tx_data <= stamp_byte(man_data, PKT_MANUAL);
                  end else begin
                     tx_data <= stamp_byte(scr_data, PKT_SCRIPT);
                  end
               end
            end
            WAIT_BUSY: begin
               if (tx_busy) begin
                  state <= WAIT_DONE;
               end else if (phase_cnt == START_LAST) begin
                  err_timeout <= 1'b1;
                  phase_cnt   <= '0;
                  state       <= GAP;
               end else begin
                  phase_cnt <= phase_cnt + CW'(1);
               end
            end
            WAIT_DONE: begin
               if (!tx_busy) begin
                  phase_cnt <= '0;
                  state     <= GAP;
               end
            end
            GAP: begin
               if (phase_cnt == GAP_LAST) begin
                  phase_cnt  <= '0;
                  sched_busy <= 1'b0;
                  state      <= IDLE;
               end else begin
                  phase_cnt <= phase_cnt + CW'(1);
               end
            end
            default: begin
               phase_cnt  <= '0;
               sched_busy <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: requesters push expected
// outcomes, a monitor pops them on every ack and checks timing rules,
// and a small UART core model answers tx_start with a busy pulse.
module tb_uart_tx_scheduler;

   localparam int HB  = 50;
   localparam int GAP = 4;
   localparam int STO = 8;

   logic       uart_clk = 1'b0;
   logic       rst_n;
   logic       script_mode;
   logic       man_req;
   logic [7:0] man_data;
   logic       man_ack;
   logic       scr_req;
   logic [7:0] scr_data;
   logic       scr_ack;
   logic       tx_busy;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       sched_busy;
   logic       err_timeout;

   logic guard_busy;
   logic bfm_busy;
   logic bfm_stall;
   logic expErr;

   int checks     = 0;
   int failures   = 0;
   int cycleCount = 0;
   int queries    = 0;

   logic [8:0] manExp[$];
   logic [8:0] scrExp[$];

   assign tx_busy = guard_busy | bfm_busy;

   always #5 uart_clk = ~uart_clk;

   uart_tx_scheduler #(
      .HB_PERIOD  (HB),
      .GAP_CYCLES (GAP),
      .START_TO   (STO)
   ) dut (
      .uart_clk    (uart_clk),
      .rst_n       (rst_n),
      .script_mode (script_mode),
      .man_req     (man_req),
      .man_data    (man_data),
      .man_ack     (man_ack),
      .scr_req     (scr_req),
      .scr_data    (scr_data),
      .scr_ack     (scr_ack),
      .tx_busy     (tx_busy),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .sched_busy  (sched_busy),
      .err_timeout (err_timeout)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_tx_start"}, tx_start, 0);
      checkOutput({tag, "_tx_data"}, tx_data, 0);
      checkOutput({tag, "_man_ack"}, man_ack, 0);
      checkOutput({tag, "_scr_ack"}, scr_ack, 0);
      checkOutput({tag, "_sched_busy"}, sched_busy, 0);
      checkOutput({tag, "_err_timeout"}, err_timeout, 0);
   endtask

   // Expected outcome: {sent, byte on the wire} or all zero when dropped.
   task automatic manSend(input logic [7:0] d);
      bit done = 0;
      if (script_mode == 1'b0) manExp.push_back({1'b1, d[7:2], 2'b01});
      else                     manExp.push_back(9'h000);
      @(negedge uart_clk);
      man_data = d;
      man_req  = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(posedge uart_clk); #1;
         if (man_ack) begin done = 1; break; end
      end
      man_req = 1'b0;
      if (!done) begin
         checks++; failures++;
         $display("[TB] FAIL man_ack_timeout actual=none expected=ack");
      end
   endtask

   task automatic scrSend(input logic [7:0] d);
      bit done = 0;
      if (script_mode == 1'b1) scrExp.push_back({1'b1, d[7:2], 2'b00});
      else                     scrExp.push_back(9'h000);
      @(negedge uart_clk);
      scr_data = d;
      scr_req  = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(posedge uart_clk); #1;
         if (scr_ack) begin done = 1; break; end
      end
      scr_req = 1'b0;
      if (!done) begin
         checks++; failures++;
         $display("[TB] FAIL scr_ack_timeout actual=none expected=ack");
      end
   endtask

   task automatic waitIdle();
      bit done = 0;
      for (int i = 0; i < 300; i++) begin
         @(posedge uart_clk); #1;
         if (!sched_busy && !tx_busy) begin done = 1; break; end
      end
      if (!done) begin
         checks++; failures++;
         $display("[TB] FAIL idle_timeout actual=busy expected=idle");
      end
      @(negedge uart_clk);
   endtask

   task automatic waitPhase(input int phase);
      for (int i = 0; i < 2 * HB; i++) begin
         @(posedge uart_clk); #1;
         if (cycleCount % HB == phase) break;
      end
   endtask

   // UART core model: busy rises 1..4 cycles after start and lasts 3..10 cycles; stall mode never answers.
   initial begin : bfm
      int d;
      int len;
      bfm_busy = 1'b0;
      expErr   = 1'b0;
      forever begin
         @(posedge uart_clk); #1;
         if (!rst_n) begin
            bfm_busy = 1'b0;
            expErr   = 1'b0;
         end else if (tx_start) begin
            if (bfm_stall) begin
               expErr = 1'b1;
            end else begin
               d   = $urandom_range(1, 4);
               len = $urandom_range(3, 10);
               for (int i = 0; i < d + len; i++) begin
                  @(negedge uart_clk);
                  if (!rst_n) break;
                  bfm_busy = (i >= d - 1) && (i < d - 1 + len);
               end
               bfm_busy = 1'b0;
            end
         end
      end
   end

   // Monitor: pops expected outcomes on acks and checks query rate, stall latency and gap length.
   initial begin : monitor
      logic       prevBusy, prevSched, prevErr, fallValid, errValid;
      int         fallCycle, errCycle, startCycle;
      logic [8:0] expv, actv;
      prevBusy = 0; prevSched = 0; prevErr = 0; fallValid = 0; errValid = 0;
      fallCycle = 0; errCycle = 0; startCycle = 0;
      forever begin
         @(posedge uart_clk); #1;
         if (!rst_n) begin
            cycleCount = 0; queries = 0;
            prevBusy = 0; prevSched = 0; prevErr = 0; fallValid = 0; errValid = 0;
         end else begin
            cycleCount++;
            if (sched_busy && prevBusy && !tx_busy) begin
               fallValid = 1; fallCycle = cycleCount;
            end
            if (!prevErr && err_timeout) begin
               checkOutput("timeout_latency", cycleCount - startCycle, STO);
               errValid = 1; errCycle = cycleCount;
            end
            if (tx_start) begin
               startCycle = cycleCount;
               fallValid  = 0;
               checkOutput("busy_on_start", sched_busy, 1);
               case (tx_data[1:0])
                  2'b10: begin
                     queries++;
                     checkOutput("query_byte", tx_data, 8'h02);
                     checkOutput("query_rate", (queries <= (cycleCount - 1) / HB), 1);
                  end
                  2'b01:   checkOutput("man_start_has_ack", man_ack, 1);
                  2'b00:   checkOutput("scr_start_has_ack", scr_ack, 1);
                  default: checkOutput("tx_type", tx_data[1:0], 0);
               endcase
            end
            if (man_ack) begin
               if (manExp.size() == 0) begin
                  checks++; failures++;
                  $display("[TB] FAIL man_ack_unexpected actual=1 expected=0");
               end else begin
                  expv = manExp.pop_front();
                  actv = (tx_start && tx_data[1:0] == 2'b01) ? {1'b1, tx_data} : 9'h000;
                  checkOutput("man_outcome", actv, expv);
               end
            end
            if (scr_ack) begin
               if (scrExp.size() == 0) begin
                  checks++; failures++;
                  $display("[TB] FAIL scr_ack_unexpected actual=1 expected=0");
               end else begin
                  expv = scrExp.pop_front();
                  actv = (tx_start && tx_data[1:0] == 2'b00) ? {1'b1, tx_data} : 9'h000;
                  checkOutput("scr_outcome", actv, expv);
               end
            end
            if (prevSched && !sched_busy) begin
               if (fallValid)     checkOutput("gap_after_busy", cycleCount - fallCycle, GAP);
               else if (errValid) checkOutput("gap_after_timeout", cycleCount - errCycle, GAP);
               checkOutput("err_sticky", err_timeout, expErr);
               fallValid = 0; errValid = 0;
            end
            prevBusy  = tx_busy;
            prevSched = sched_busy;
            prevErr   = err_timeout;
         end
      end
   end

   // Directed scenarios followed by a randomized mix of sources, modes and stalls.
   task automatic applyStimulus();
      logic [7:0] b0, b1, md, sd;
      int         n, ackCount, pat;

      // ownership drop
      script_mode = 1'b1;
      fork
         manSend(8'h3C);
         scrSend(8'hF3);
      join
      waitIdle();

      // heartbeat beats a script request raised in the wrap cycle
      waitPhase(30);
      waitIdle();
      waitPhase(0);
      b0 = 8'h00; b1 = 8'h00; n = 0;
      fork
         scrSend(8'hC7);
      join_none
      for (int i = 0; i < 120 && n < 2; i++) begin
         @(posedge uart_clk); #1;
         if (tx_start) begin
            if (n == 0) b0 = tx_data; else b1 = tx_data;
            n++;
         end
      end
      wait fork;
      checkOutput("hb_first_byte", b0, 8'h02);
      checkOutput("hb_second_byte", b1, 8'hC4);
      waitIdle();

      // busy guard
      script_mode = 1'b0;
      guard_busy  = 1'b1;
      fork
         manSend(8'h9C);
      join_none
      for (int i = 0; i < 6; i++) begin
         @(posedge uart_clk); #1;
         checkOutput("guard_no_start", tx_start, 0);
         checkOutput("guard_no_ack", man_ack, 0);
      end
      @(negedge uart_clk);
      guard_busy = 1'b0;
      wait fork;
      waitIdle();

      // withdrawn request
      guard_busy = 1'b1;
      man_data   = 8'h11;
      man_req    = 1'b1;
      ackCount   = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge uart_clk); #1;
         if (man_ack) ackCount++;
      end
      @(negedge uart_clk);
      man_req    = 1'b0;
      guard_busy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge uart_clk); #1;
         if (man_ack) ackCount++;
      end
      checkOutput("withdraw_no_ack", ackCount, 0);
      waitIdle();

      // stall then recovery
      script_mode = 1'b1;
      bfm_stall   = 1'b1;
      scrSend(8'h6B);
      waitIdle();
      bfm_stall = 1'b0;
      checkOutput("err_set", err_timeout, 1);
      scrSend(8'h2A);
      waitIdle();
      checkOutput("err_stays", err_timeout, 1);

      // randomized mix
      for (int it = 0; it < 40; it++) begin
         pat         = $urandom_range(0, 2);
         script_mode = 1'($urandom_range(0, 1));
         bfm_stall   = ($urandom_range(0, 7) == 0);
         md          = 8'($urandom);
         sd          = 8'($urandom);
         case (pat)
            0: manSend(md);
            1: scrSend(sd);
            default: begin
               fork
                  manSend(md);
                  scrSend(sd);
               join
            end
         endcase
         waitIdle();
         bfm_stall = 1'b0;
         repeat ($urandom_range(0, 3)) @(negedge uart_clk);
      end
   endtask

   initial begin : watchdog
      #500000;
      $display("[TB] FAIL watchdog actual=running expected=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      bit seen;
      rst_n = 1'b0; script_mode = 1'b0; man_req = 1'b0; scr_req = 1'b0;
      man_data = 8'h00; scr_data = 8'h00; guard_busy = 1'b0; bfm_stall = 1'b0;
      repeat (3) @(posedge uart_clk);
      #1;
      checkReset("por");
      @(negedge uart_clk);
      rst_n = 1'b1;

      applyStimulus();

      // reset asserted mid-transfer while the core reports busy
      waitIdle();
      script_mode = 1'b0;
      manSend(8'h5C);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge uart_clk); #1;
         if (tx_busy) begin seen = 1; break; end
      end
      checkOutput("midreset_busy_seen", seen, 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkReset("async");
      repeat (2) @(negedge uart_clk);
      rst_n = 1'b1;

      // first manual request after reset: one-cycle latency
      @(negedge uart_clk);
      manExp.push_back({1'b1, 8'hA5});
      man_data = 8'hA4;
      man_req  = 1'b1;
      @(posedge uart_clk); #1;
      checkOutput("lat_tx_start", tx_start, 1);
      checkOutput("lat_man_ack", man_ack, 1);
      checkOutput("lat_tx_data", tx_data, 8'hA5);
      man_req = 1'b0;
      waitIdle();

      repeat (5) @(negedge uart_clk);
      checkOutput("man_queue_empty", manExp.size(), 0);
      checkOutput("scr_queue_empty", scrExp.size(), 0);
      checkOutput("query_count", (queries == cycleCount / HB) || (queries + 1 == cycleCount / HB), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
